vga_sync_decoder: RTL and testbench

//   Receive side of the 640x480 VGA timing: samples active-low hsync_in/vsync_in
//   at pixel rate, measures line and frame periods, and regenerates x, y and

---
 rtl/vga_sync_decoder.sv | 135 +++++++++++++
 tb/tb_vga_sync_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers x/y/activevideo from active-low hsync/vsync sampled on pixel_en,
// verifies line and frame periods and declares lock after consecutive good frames.
module vga_sync_decoder #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int WHOLE_LINE   = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int WHOLE_FRAME  = 525,
  parameter int LOCK_FRAMES  = 2,
  parameter int XBITS        = 10,
  parameter int YBITS        = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pixel_en,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [XBITS-1:0] x,
  output logic [YBITS-1:0] y,
  output logic             activevideo,
  output logic             locked,
  output logic             sync_error
);

  localparam logic [XBITS-1:0] X_LAST    = XBITS'(WHOLE_LINE - 1);
  localparam logic [XBITS-1:0] X_SYNC    = XBITS'(H_SYNC_START);
  localparam logic [XBITS-1:0] X_VIS     = XBITS'(H_VISIBLE);
  localparam logic [YBITS-1:0] Y_LAST    = YBITS'(WHOLE_FRAME - 1);
  localparam logic [YBITS-1:0] Y_SYNC    = YBITS'(V_SYNC_START);
  localparam logic [YBITS-1:0] Y_VIS     = YBITS'(V_VISIBLE);
  localparam logic [XBITS:0]   LINE_LEN  = (XBITS+1)'(WHOLE_LINE);
  localparam logic [XBITS:0]   LINE_TO   = (XBITS+1)'(2*WHOLE_LINE - 1);
  localparam logic [XBITS:0]   LINE_SAT  = (XBITS+1)'(2*WHOLE_LINE);
  localparam logic [YBITS:0]   FRAME_LEN = (YBITS+1)'(WHOLE_FRAME);
  localparam logic [YBITS:0]   FRAME_TO  = (YBITS+1)'(2*WHOLE_FRAME - 1);
  localparam logic [YBITS:0]   FRAME_SAT = (YBITS+1)'(2*WHOLE_FRAME);
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK_H, VERIFY, LOCKED} state_t;

  state_t           state, state_nxt;
  logic             hs_prev, vs_prev;
  logic [XBITS:0]   line_cnt, line_cnt_nxt;
  logic [YBITS:0]   frame_cnt, frame_cnt_nxt;
  logic [3:0]       good_frames, good_nxt;
  logic [XBITS-1:0] x_nxt;
  logic [YBITS-1:0] y_nxt;
  logic             locked_nxt, active_nxt;
  logic             hfall, vfall, x_wrap, line_err, frame_err, timeout, err;

  always_comb begin
    hfall  = hs_prev & ~hsync_in;
    vfall  = vs_prev & ~vsync_in;
    x_wrap = ~hfall & (x == X_LAST);

    x_nxt = hfall ? X_SYNC : (x_wrap ? '0 : x + 1'b1);
    if (vfall)       y_nxt = Y_SYNC;
    else if (x_wrap) y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
    else             y_nxt = y;

    line_cnt_nxt = hfall ? (XBITS+1)'(1) :
                   (line_cnt == LINE_SAT) ? line_cnt : line_cnt + 1'b1;
    if (vfall)                              frame_cnt_nxt = '0;
    else if (hfall && frame_cnt != FRAME_SAT) frame_cnt_nxt = frame_cnt + 1'b1;
    else                                    frame_cnt_nxt = frame_cnt;

    // The partial frame seen in TRACK_H is never period-checked.
    line_err  = (state != SEARCH) & hfall & (line_cnt != LINE_LEN);
    frame_err = ((state == VERIFY) | (state == LOCKED)) & vfall & (frame_cnt != FRAME_LEN);
    timeout   = (state != SEARCH) &
                ((~hfall & (line_cnt == LINE_TO)) | (hfall & ~vfall & (frame_cnt == FRAME_TO)));
    err       = line_err | frame_err;

    state_nxt  = state;
    locked_nxt = locked;
    good_nxt   = good_frames;
    case (state)
      SEARCH:  if (hfall) state_nxt = TRACK_H;
      TRACK_H: if (vfall) begin
                 state_nxt = VERIFY;
                 good_nxt  = '0;
               end
      VERIFY:  if (vfall) begin
                 good_nxt = good_frames + 4'd1;
                 if (good_frames + 4'd1 == LOCK_N) begin
                   state_nxt  = LOCKED;
                   locked_nxt = 1'b1;
                 end
               end
      default: ;
    endcase
    if (err) begin
      state_nxt  = TRACK_H;
      locked_nxt = 1'b0;
    end
    if (timeout) begin
      state_nxt  = SEARCH;
      locked_nxt = 1'b0;
    end

    active_nxt = locked_nxt & (x_nxt < X_VIS) & (y_nxt < Y_VIS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SEARCH;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      line_cnt    <= '0;
      frame_cnt   <= '0;
      good_frames <= '0;
      x           <= '0;
      y           <= '0;
      locked      <= 1'b0;
      activevideo <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      sync_error <= pixel_en & (err | timeout);
      if (pixel_en) begin
        state       <= state_nxt;
        hs_prev     <= hsync_in;
        vs_prev     <= vsync_in;
        line_cnt    <= line_cnt_nxt;
        frame_cnt   <= frame_cnt_nxt;
        good_frames <= good_nxt;
        x           <= x_nxt;
        y           <= y_nxt;
        locked      <= locked_nxt;
        activevideo <= active_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized scoreboard bench for vga_sync_decoder using a reduced raster so
// many frames, lock/relock cycles and fault injections fit in a short run.
module tb_vga_sync_decoder;

  localparam int WL  = 20;
  localparam int HV  = 12;
  localparam int HSS = 14;
  localparam int HSW = 3;
  localparam int WF  = 12;
  localparam int VV  = 8;
  localparam int VSS = 9;
  localparam int VSW = 2;
  localparam int LF  = 2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       av;
    logic       lk;
    logic       se;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_en = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] x, y;
  logic       activevideo, locked, sync_error;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .WHOLE_LINE(WL),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .WHOLE_FRAME(WF),
    .LOCK_FRAMES(LF), .XBITS(10), .YBITS(10)
  ) dut (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .activevideo(activevideo), .locked(locked),
    .sync_error(sync_error)
  );

  always #5 clock = ~clock;

  // Reference model: timestamps of the last edges and counted lines per frame.
  int m_x, m_y, m_mode, m_good, m_t, m_last_h, m_lines;
  bit m_hs, m_vs, m_locked;

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_mode = 0; m_good = 0;
    m_t = 0; m_last_h = 0; m_lines = 0;
    m_hs = 1; m_vs = 1; m_locked = 0;
  endfunction

  function automatic exp_t model_tick(bit hs, bit vs);
    exp_t e;
    bit hf, vf, bad, tout;
    int el, lines_now, nx, ny;
    hf = m_hs && !hs;
    vf = m_vs && !vs;
    m_t++;
    el = m_t - m_last_h;
    lines_now = m_lines + (hf ? 1 : 0);
    bad = 0;
    tout = 0;
    if (m_mode != 0) begin
      if (hf && el != WL) bad = 1;
      if (vf && m_mode >= 2 && m_lines != WF) bad = 1;
      if (!hf && el == 2*WL - 1) tout = 1;
      if (hf && !vf && lines_now == 2*WF) tout = 1;
    end
    if (tout) begin
      m_mode = 0; m_locked = 0;
    end else if (bad) begin
      m_mode = 1; m_locked = 0;
    end else if (m_mode == 0 && hf) begin
      m_mode = 1;
    end else if (m_mode == 1 && vf) begin
      m_mode = 2; m_good = 0;
    end else if (m_mode == 2 && vf) begin
      m_good++;
      if (m_good == LF) begin
        m_mode = 3; m_locked = 1;
      end
    end
    nx = hf ? HSS : (m_x + 1) % WL;
    if (vf) ny = VSS;
    else if (!hf && m_x == WL - 1) ny = (m_y + 1) % WF;
    else ny = m_y;
    m_x = nx;
    m_y = ny;
    m_hs = hs;
    m_vs = vs;
    if (hf) m_last_h = m_t;
    m_lines = vf ? 0 : lines_now;
    e.x  = 10'(m_x);
    e.y  = 10'(m_y);
    e.av = m_locked && (m_x < HV) && (m_y < VV);
    e.lk = m_locked;
    e.se = bad || tout;
    return e;
  endfunction

  // Source raster generator with fault injection hooks.
  int sx, sy, mask_left;
  bit drop_px, drop_ln;

  task automatic pix(input bit hs, input bit vs);
    hsync_in = hs;
    vsync_in = vs;
    pixel_en = 1'b1;
    exp_q.push_back(model_tick(hs, vs));
    @(posedge clock); #1;
    pixel_en = 1'b0;
    repeat ($urandom_range(1, 2)) @(posedge clock);
    #1;
  endtask

  task automatic gen_tick();
    bit hs, vs;
    hs = !(sx >= HSS && sx < HSS + HSW);
    vs = !(sy >= VSS && sy < VSS + VSW);
    if (mask_left > 0) begin
      hs = 1'b1;
      mask_left--;
    end
    pix(hs, vs);
    sx++;
    if (drop_px && sx == 3) begin
      sx++;
      drop_px = 0;
    end
    if (sx >= WL) begin
      sx = 0;
      sy++;
      if (drop_ln && sy == 3) begin
        sy++;
        drop_ln = 0;
      end
      if (sy >= WF) sy = 0;
    end
  endtask

  task automatic do_reset();
    exp_t e;
    e = '0;
    pixel_en = 1'b0;
    reset = 1'b1;
    model_reset();
    exp_q.push_back(e);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Monitor: pops on every sampling edge, checks that outputs hold in between.
  initial begin
    exp_t got, hold;
    hold = '0;
    forever begin
      @(posedge clock);
      if (reset || pixel_en) begin
        #2;
        got = {x, y, activevideo, locked, sync_error};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample: no expected entry queued at %0t", $time);
        end else begin
          hold = exp_q.pop_front();
          if (got !== hold) begin
            errors++;
            $display("FAIL sample @%0t: x/y/av/lk/se got %0d/%0d/%0b/%0b/%0b expected %0d/%0d/%0b/%0b/%0b",
                     $time, got.x, got.y, got.av, got.lk, got.se,
                     hold.x, hold.y, hold.av, hold.lk, hold.se);
          end
        end
      end else begin
        #2;
        got = {x, y, activevideo, locked, sync_error};
        checks++;
        if (got !== {hold.x, hold.y, hold.av, hold.lk, 1'b0}) begin
          errors++;
          $display("FAIL idle @%0t: x/y/av/lk/se got %0d/%0d/%0b/%0b/%0b expected %0d/%0d/%0b/%0b/0",
                   $time, got.x, got.y, got.av, got.lk, got.se,
                   hold.x, hold.y, hold.av, hold.lk);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int frames;
    sx = $urandom_range(0, WL - 1);
    sy = $urandom_range(0, WF - 1);
    mask_left = 0;
    drop_px = 0;
    drop_ln = 0;
    do_reset();
    for (int ep = 0; ep < 12; ep++) begin
      frames = $urandom_range(4, 5);
      repeat (frames * WL * WF) gen_tick();
      case (ep % 4)
        0: drop_px = 1;
        1: drop_ln = 1;
        2: mask_left = $urandom_range(2*WL, 3*WL);
        default: do_reset();
      endcase
    end
    repeat (2 * WL * WF) gen_tick();
    repeat (3) @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
